// File: rtl/vga_box_pixel_gen.sv
// Pixel-colour source for the VGA timing block: a solid square on a background that
// bounces around the visible area, moving once per frame.
module vga_box_pixel_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned BOX_SIZE = 32,
   parameter int unsigned STEP     = 4,
   parameter int unsigned X_INIT   = 100,
   parameter int unsigned Y_INIT   = 50,
   parameter logic [2:0]  BG_COLOR = 3'b000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] iCtrH,
   input  logic [9:0] iCtrV,
   input  logic [2:0] iColor,
   input  logic       iPause,
   output logic [2:0] oRGB,
   output logic       oFrameTick,
   output logic [9:0] oBoxX,
   output logic [9:0] oBoxY
);

   localparam logic [10:0] XMAX   = 11'(H_ACTIVE - BOX_SIZE);
   localparam logic [10:0] YMAX   = 11'(V_ACTIVE - BOX_SIZE);
   localparam logic [10:0] STEP11 = 11'(STEP);
   localparam logic [10:0] BOX11  = 11'(BOX_SIZE);
   localparam logic [9:0]  HACT   = 10'(H_ACTIVE);
   localparam logic [9:0]  VACT   = 10'(V_ACTIVE);

   typedef enum logic [1:0] {StWaitSync, StRun, StPaused} state_e;

   state_e      state;
   logic        cond, cond_q;
   logic        dir_x, dir_y;      // 1 = moving towards 0
   logic [10:0] x_nxt, y_nxt;      // {dir, position}
   logic [10:0] x_end, y_end;
   logic        visible, in_box;
   logic [2:0]  pix;

   // Returns {new_dir, new_pos}; clamps at 0 and lim instead of overshooting.
   function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                             input logic [10:0] lim);
      logic [10:0] p;
      p = {1'b0, pos};
      if (!dir) begin
         if (p + STEP11 >= lim) return {1'b1, lim[9:0]};
         else                   return {1'b0, 10'(p + STEP11)};
      end else begin
         if (p <= STEP11) return {1'b0, 10'd0};
         else             return {1'b1, 10'(p - STEP11)};
      end
   endfunction

   always_comb begin
      cond    = (iCtrH == 10'd0) && (iCtrV == VACT);
      x_nxt   = step_axis(oBoxX, dir_x, XMAX);
      y_nxt   = step_axis(oBoxY, dir_y, YMAX);
      x_end   = {1'b0, oBoxX} + BOX11 - 11'd1;
      y_end   = {1'b0, oBoxY} + BOX11 - 11'd1;
      visible = (iCtrH < HACT) && (iCtrV < VACT);
      in_box  = (iCtrH >= oBoxX) && ({1'b0, iCtrH} <= x_end) &&
                (iCtrV >= oBoxY) && ({1'b0, iCtrV} <= y_end);
      pix     = 3'b000;
      if (visible) pix = in_box ? iColor : BG_COLOR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StWaitSync;
         cond_q     <= 1'b0;
         oFrameTick <= 1'b0;
         oRGB       <= 3'b000;
         oBoxX      <= 10'(X_INIT);
         oBoxY      <= 10'(Y_INIT);
         dir_x      <= 1'b0;
         dir_y      <= 1'b0;
      end else begin
         cond_q     <= cond;
         // Rising edge only, so a counter held over several clocks still gives one pulse.
         oFrameTick <= cond & ~cond_q;
         oRGB       <= pix;
         if (oFrameTick) begin
            unique case (state)
               StWaitSync: state <= iPause ? StPaused : StRun;
               StRun: begin
                  if (iPause) begin
                     state <= StPaused;
                  end else begin
                     oBoxX <= x_nxt[9:0];
                     dir_x <= x_nxt[10];
                     oBoxY <= y_nxt[9:0];
                     dir_y <= y_nxt[10];
                  end
               end
               StPaused: if (!iPause) state <= StRun;
               default:  state <= StWaitSync;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_box_pixel_gen.sv
// Directed bench for vga_box_pixel_gen: reset, pixel map, frame tick, bounce, pause, reset.
module tb_vga_box_pixel_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] iCtrH = 10'd1;
   logic [9:0] iCtrV = 10'd1;
   logic [2:0] iColor = 3'b100;
   logic       iPause = 1'b0;
   logic [2:0] oRGB;
   logic       oFrameTick;
   logic [9:0] oBoxX;
   logic [9:0] oBoxY;

   int n_cmp = 0;
   int n_err = 0;
   int tick_cnt = 0;
   int frames = 0;
   int m = 0;   // moves applied since reset

   vga_box_pixel_gen dut (
      .clk        (clk),
      .rst        (rst),
      .iCtrH      (iCtrH),
      .iCtrV      (iCtrV),
      .iColor     (iColor),
      .iPause     (iPause),
      .oRGB       (oRGB),
      .oFrameTick (oFrameTick),
      .oBoxX      (oBoxX),
      .oBoxY      (oBoxY)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (oFrameTick) tick_cnt++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Drive one pixel, expect its colour one clock later.
   task automatic pix(input int h, input int v, input logic [2:0] exp, input string tag);
      iCtrH = 10'(h);
      iCtrV = 10'(v);
      @(posedge clk); #1;
      check_eq(tag, 32'(oRGB), 32'(exp));
   endtask

   // One frame: counters sit at (0,480) for two clocks, then move on.
   task automatic frame();
      iCtrH = 10'd0;
      iCtrV = 10'd480;
      @(posedge clk); #1;
      @(posedge clk); #1;
      iCtrH = 10'd1;
      @(posedge clk); #1;
      frames++;
   endtask

   task automatic run_to(input int target);
      while (m < target) begin
         frame();
         m++;
      end
   endtask

   task automatic check_pos(input string tag, input int x, input int y);
      check_eq({tag, "_x"}, 32'(oBoxX), 32'(x));
      check_eq({tag, "_y"}, 32'(oBoxY), 32'(y));
   endtask

   initial begin
      repeat (5) @(posedge clk);
      #1;
      check_eq("rst_rgb", 32'(oRGB), 32'd0);
      check_eq("rst_tick", 32'(oFrameTick), 32'd0);
      check_pos("rst", 100, 50);
      rst = 1'b0;

      pix(100, 50, 3'b100, "pix_tl");
      pix(131, 81, 3'b100, "pix_br");
      pix(132, 81, 3'b000, "pix_right");
      pix(99, 50, 3'b000, "pix_left");
      pix(700, 50, 3'b000, "pix_offscreen");
      iColor = 3'b011;
      pix(110, 60, 3'b011, "pix_newcolor");
      iColor = 3'b100;

      // First tick only leaves the wait state.
      frame();
      check_pos("f1", 100, 50);
      check_eq("f1_ticks", 32'(tick_cnt), 32'd1);
      frame(); m++;
      check_pos("f2", 104, 54);
      frame(); m++;
      check_pos("f3", 108, 58);
      check_eq("f3_ticks", 32'(tick_cnt), 32'd3);

      iPause = 1'b1;
      repeat (3) frame();
      check_pos("paused", 108, 58);
      iPause = 1'b0;
      frame();
      check_pos("resume1", 108, 58);
      frame(); m++;
      check_pos("resume2", 112, 62);

      run_to(99);  check_pos("m99", 496, 446);
      run_to(100); check_pos("m100", 500, 448);
      run_to(101); check_pos("m101", 504, 444);
      run_to(126); check_pos("m126", 604, 344);
      run_to(127); check_pos("m127", 608, 340);
      run_to(128); check_pos("m128", 604, 336);
      run_to(211); check_pos("m211", 272, 4);
      run_to(212); check_pos("m212", 268, 0);
      run_to(213); check_pos("m213", 264, 4);
      run_to(278); check_pos("m278", 4, 264);
      run_to(279); check_pos("m279", 0, 268);
      run_to(280); check_pos("m280", 4, 272);
      check_eq("tick_per_frame", 32'(tick_cnt), 32'(frames));

      // Mid-frame reset with the box under the beam.
      iCtrH = 10'd10;
      iCtrV = 10'd280;
      rst   = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_pos("mrst", 100, 50);
      check_eq("mrst_rgb", 32'(oRGB), 32'd0);
      pix(100, 50, 3'b100, "mrst_pix");
      frame();
      check_pos("mrst_f1", 100, 50);
      frame();
      check_pos("mrst_f2", 104, 54);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
